// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads, vector pixel writes and a
// per-frame clear engine share one synchronous RAM, one access per clock.
module fb_arbiter #(
    parameter int unsigned AW         = 17,
    parameter int unsigned DW         = 4,
    parameter int unsigned CLEAR_LEN  = 76800,
    parameter int unsigned CLEAR_VAL  = 0,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          clk_i,
    input  logic          reset,
    input  logic          scan_req,
    input  logic [AW-1:0] scan_addr,
    output logic [DW-1:0] scan_data,
    output logic          scan_valid,
    input  logic          vec_req,
    input  logic [AW-1:0] vec_addr,
    input  logic [DW-1:0] vec_data,
    output logic          vec_ack,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;

    localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(CLEAR_LEN - 1);
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          vec_ack_q, vec_ack_d;
    logic          scan_valid_q, scan_valid_d;

    logic vec_live, clr_active, gnt_vec, gnt_clr;

    always_comb begin
        // A request still held during its ack cycle is the same request, not a new one.
        vec_live   = vec_req && !vec_ack_q;
        clr_active = (state_q == CLEAR);
        gnt_vec    = !scan_req && vec_live && (!clr_active || starve_q == STARVE_SAT);
        gnt_clr    = !scan_req && clr_active && !gnt_vec;

        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        vec_ack_d    = gnt_vec;
        scan_valid_d = mem_en_q && !mem_we_q;

        if (scan_req) begin
            mem_en_d   = 1'b1;
            mem_addr_d = scan_addr;
        end else if (gnt_vec) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = vec_addr;
            mem_wdata_d = vec_data;
        end else if (gnt_clr) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q;
            mem_wdata_d = DW'(CLEAR_VAL);
        end

        if (!vec_live || gnt_vec) begin
            starve_d = '0;
        end else if (starve_q != STARVE_SAT) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (gnt_clr) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            starve_q     <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            vec_ack_q    <= 1'b0;
            scan_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            vec_ack_q    <= vec_ack_d;
            scan_valid_q <= scan_valid_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign vec_ack    = vec_ack_q;
    assign scan_valid = scan_valid_q;
    assign scan_data  = scan_valid_q ? mem_rdata : '0;
    assign clr_busy   = (state_q == CLEAR);
    assign clr_done   = (state_q == DONE);

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a small RAM model; CLEAR_LEN is
// shrunk to 16 so whole clears fit in a short run.
module tb_fb_arbiter;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        scan_req;
    logic [16:0] scan_addr;
    logic [3:0]  scan_data;
    logic        scan_valid;
    logic        vec_req;
    logic [16:0] vec_addr;
    logic [3:0]  vec_data;
    logic        vec_ack;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata = '0;

    fb_arbiter #(
        .AW(17), .DW(4), .CLEAR_LEN(16), .CLEAR_VAL(0), .STARVE_MAX(8)
    ) dut (
        .clk_i(clk_i), .reset(reset),
        .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_data(scan_data), .scan_valid(scan_valid),
        .vec_req(vec_req), .vec_addr(vec_addr), .vec_data(vec_data),
        .vec_ack(vec_ack),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk_i = ~clk_i;

    // RAM model with a back-door load port used while the DUT is in reset
    logic [3:0]  ram [0:131071];
    logic        ld_en = 1'b0;
    logic [16:0] ld_addr = '0;
    logic [3:0]  ld_data = '0;

    always @(posedge clk_i) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    // Bus monitor: clear writes are data 0 at addresses below 16
    int          clr_writes = 0;
    int          vec_writes = 0;
    int          clr_seq_err = 0;
    logic [16:0] clr_exp = '0;

    always @(negedge clk_i) begin
        if (mem_en && mem_we) begin
            if (mem_wdata == 4'h0 && mem_addr < 17'd16) begin
                clr_writes++;
                if (mem_addr !== clr_exp) clr_seq_err++;
                clr_exp++;
            end else begin
                vec_writes++;
            end
        end
        if (reset || clr_done) clr_exp = '0;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic preload(input logic [16:0] a, input logic [3:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_bus"}, {mem_en, mem_we, mem_addr, mem_wdata}, 32'h0);
        chk({name, "_flags"}, {scan_valid, scan_data, vec_ack, clr_busy, clr_done}, 32'h0);
    endtask

    task automatic wait_done(input string name, input int bound);
        int got;
        got = 0;
        for (int i = 0; i < bound && got == 0; i++) begin
            step();
            if (clr_done) got = 1;
        end
        chk({name, "_done_timeout"}, got, 1);
        step();
    endtask

    typedef struct {
        logic        sreq;
        logic [16:0] saddr;
        logic        vreq;
        logic [16:0] vaddr;
        logic [3:0]  vdata;
        logic        en;
        logic        we;
        logic [16:0] addr;
        logic [3:0]  wdata;
        logic        ack;
        logic        valid;
        logic [3:0]  sdata;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int c0, v0, got, wait_cyc, busy_cnt, done_cnt, rd, oth;

        tbl[0] = '{1'b1, 17'h00010, 1'b0, 17'h0,     4'h0, 1'b1, 1'b0, 17'h00010, 4'h0, 1'b0, 1'b1, 4'hA};
        tbl[1] = '{1'b0, 17'h0,     1'b1, 17'h01234, 4'h7, 1'b1, 1'b1, 17'h01234, 4'h7, 1'b1, 1'b0, 4'h0};
        tbl[2] = '{1'b1, 17'h01234, 1'b0, 17'h0,     4'h0, 1'b1, 1'b0, 17'h01234, 4'h7, 1'b0, 1'b1, 4'h7};
        tbl[3] = '{1'b1, 17'h00020, 1'b1, 17'h00100, 4'h3, 1'b1, 1'b0, 17'h00020, 4'h7, 1'b0, 1'b1, 4'h5};
        tbl[4] = '{1'b0, 17'h0,     1'b0, 17'h0,     4'h0, 1'b0, 1'b0, 17'h00020, 4'h7, 1'b0, 1'b0, 4'h0};
        tbl[5] = '{1'b0, 17'h0,     1'b1, 17'h1FFFF, 4'hF, 1'b1, 1'b1, 17'h1FFFF, 4'hF, 1'b1, 1'b0, 4'h0};

        reset = 1'b1; scan_req = 0; scan_addr = '0; vec_req = 0; vec_addr = '0;
        vec_data = '0; clr_start = 0;
        step();
        preload(17'h00010, 4'hA);
        preload(17'h00020, 4'h5);
        chk_all_zero("reset");
        reset = 1'b0;
        step();
        chk_all_zero("post_reset");

        foreach (tbl[k]) begin
            scan_req = tbl[k].sreq; scan_addr = tbl[k].saddr;
            vec_req = tbl[k].vreq; vec_addr = tbl[k].vaddr; vec_data = tbl[k].vdata;
            step();
            chk($sformatf("tbl%0d_cmd", k), {mem_en, mem_we, mem_addr, mem_wdata},
                {tbl[k].en, tbl[k].we, tbl[k].addr, tbl[k].wdata});
            chk($sformatf("tbl%0d_ack", k), vec_ack, tbl[k].ack);
            scan_req = 0; vec_req = 0;
            step();
            chk($sformatf("tbl%0d_rd", k), {scan_valid, scan_data}, {tbl[k].valid, tbl[k].sdata});
            step();
        end

        // vec_req still held in the ack cycle must not cause a second write
        v0 = vec_writes;
        vec_req = 1; vec_addr = 17'h00140; vec_data = 4'h6;
        step();
        chk("hold_ack", {vec_ack, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 17'h00140, 4'h6});
        step();
        chk("hold_no_rewrite", {vec_ack, mem_en}, 2'b00);
        vec_req = 0;
        step();
        chk("hold_write_count", vec_writes - v0, 1);

        // reset between read command and data return drops scan_valid
        scan_req = 1; scan_addr = 17'h00010;
        step();
        chk("rdrst_cmd", {mem_en, mem_we}, 2'b10);
        scan_req = 0; reset = 1;
        step();
        chk("rdrst_valid", {scan_valid, scan_data}, 5'h0);
        reset = 0;
        step();

        // plain clear, with a second clr_start mid-clear
        c0 = clr_writes;
        clr_start = 1;
        step();
        chk("clrA_busy_start", clr_busy, 1);
        busy_cnt = 1; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            clr_start = (i == 5);
            step();
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        clr_start = 0;
        chk("clrA_busy_cycles", busy_cnt, 16);
        chk("clrA_done_pulses", done_cnt, 1);
        chk("clrA_writes", clr_writes - c0, 16);

        // clear with a continuous vector request: starvation override on the 9th wait
        c0 = clr_writes; v0 = vec_writes;
        clr_start = 1;
        step();
        clr_start = 0;
        vec_req = 1; vec_addr = 17'h00200; vec_data = 4'h9;
        got = 0; wait_cyc = 0;
        for (int i = 1; i <= 30 && got == 0; i++) begin
            step();
            if (vec_ack) begin got = 1; wait_cyc = i; end
        end
        chk("starve_wait", wait_cyc, 9);
        chk("starve_cmd", {mem_we, mem_addr, mem_wdata}, {1'b1, 17'h00200, 4'h9});
        step();
        vec_req = 0;
        wait_done("clrB", 60);
        chk("clrB_writes", clr_writes - c0, 16);
        chk("clrB_vec_writes", vec_writes - v0, 1);

        // 20 cycles of scan with clear and vector both pending
        c0 = clr_writes; v0 = vec_writes;
        clr_start = 1; scan_req = 1; scan_addr = 17'h00010;
        vec_req = 1; vec_addr = 17'h00210; vec_data = 4'hC;
        rd = 0; oth = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            clr_start = 0;
            if (mem_en && !mem_we) rd++;
            else if (mem_en) oth++;
        end
        scan_req = 0;
        chk("scan_reads", rd, 20);
        chk("scan_other", oth, 0);
        step();
        chk("scan_then_vec", {vec_ack, mem_we, mem_addr}, {1'b1, 1'b1, 17'h00210});
        step();
        vec_req = 0;
        wait_done("clrC", 60);
        chk("clrC_writes", clr_writes - c0, 16);
        chk("clrC_vec_writes", vec_writes - v0, 1);

        // reset while the clear counter sits at 5
        clr_start = 1;
        step();
        clr_start = 0;
        repeat (5) step();
        chk("clrD_at4", {mem_we, mem_addr}, {1'b1, 17'd4});
        reset = 1;
        step();
        chk("clrD_reset", {clr_busy, clr_done, mem_en}, 3'b000);
        reset = 0;
        busy_cnt = 0; done_cnt = 0;
        repeat (10) begin
            step();
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        chk("clrD_no_resume", busy_cnt, 0);
        chk("clrD_no_done", done_cnt, 0);
        clr_start = 1;
        step();
        clr_start = 0;
        step();
        chk("clrD_restart_addr", {mem_we, mem_addr, mem_wdata}, {1'b1, 17'd0, 4'h0});
        wait_done("clrD", 40);
        chk("clr_sequence_errors", clr_seq_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Arbitrates one single-port synchronous framebuffer RAM between three requesters:
  - video scanout reads,
  - vector-generator pixel writes,
  - an internal per-frame clear engine.
- Sits between the vector rasterizer and the 640-wide video output path in the game top, on the 50 MHz pixel domain.
- Grants at most one RAM access per clock and sequences the frame clear.

Parameters:
AW, 17, RAM address width
DW, 4, pixel data width
CLEAR_LEN, 76800, number of words erased per clear (addresses 0..CLEAR_LEN-1)
CLEAR_VAL, 0, data written by clear engine
STARVE_MAX, 8, vector wait cycles after which vector beats clear

Ports:
clk_i  in  1  system clock
reset  in  1  synchronous, active-high reset
scan_req  in  1  scanout read request (level, sampled each cycle)
scan_addr  in  AW  scanout read address
scan_data  out  DW  read data, valid when scan_valid=1
scan_valid  out  1  one-cycle pulse, read data returned
vec_req  in  1  vector write request, held until vec_ack
vec_addr  in  AW  vector write address
vec_data  in  DW  vector write data
vec_ack  out  1  one-cycle pulse, write issued
clr_start  in  1  pulse, begin frame clear (driven at vblank start)
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse, clear finished
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid the cycle after a read command

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high.
- Values while reset is asserted (and on the following cycle): all outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, scan_valid, scan_data, vec_ack, clr_busy, clr_done). Internal state: clear FSM in IDLE, clear counter 0, starvation counter 0.
- Arbitration in cycle T (combinational on requests), winning command registered onto the mem_* bus at T+1. Priority order:
  1. scan_req always wins.
  2. Vector wins over clear if its starvation counter == STARVE_MAX.
  3. Otherwise clear (when clr_busy).
  4. Otherwise vector.
- Scan read:
  - Command at T+1: mem_en=1, mem_we=0.
  - scan_valid=1 at T+2, with scan_data = mem_rdata (combinational pass-through that cycle).
  - Back-to-back scan requests give one read per cycle, fully pipelined.
- Vector write:
  - On grant, the command (mem_we=1, vec_addr/vec_data) and vec_ack are both asserted at T+1.
  - The requester drops or updates vec_req in the cycle after vec_ack.
  - The arbiter must not issue a second write for the same request: vec_req is ignored in the cycle vec_ack is high.
- Starvation counter:
  - Increments each cycle vec_req=1 and vector is not granted.
  - Saturates at STARVE_MAX.
  - Clears on vec_ack or when vec_req=0.
  - Scan stall does not bypass priority: scan still wins.
- Clear FSM:
  - States: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_start: counter=0, clr_busy=1 from the next cycle.
  - CLEAR: each granted cycle writes CLEAR_VAL at the counter address, then increments the counter. Cycles not granted hold the counter.
  - CLEAR -> DONE after the write at CLEAR_LEN-1 is issued.
  - DONE: clr_done=1 for one cycle, clr_busy=0, then back to IDLE.
  - clr_start while CLEAR or DONE is ignored: no restart, no extra clr_done.
- Counter width: the address counter is AW bits and never wraps past CLEAR_LEN-1.
- Idle bus: when no grant, mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their last values.
- Reset mid-clear: FSM returns to IDLE, clr_done not pulsed, partial clear is not resumed.
- Reset mid-read: a scan_valid pending for T+2 is dropped.
- Simultaneous scan_req and vec_req with starvation saturated: scan wins, vector is granted the first cycle scan_req=0.

Test Plan:
- Reset, then scan_req=1 with scan_addr=0x00010 at T, RAM preloaded 0xA:
  - mem_en=1, mem_we=0, mem_addr=0x00010 at T+1.
  - scan_valid=1, scan_data=0xA at T+2.
- vec_req with addr=0x1234, data=0x7, no contention: mem_we=1, mem_addr=0x1234, mem_wdata=0x7 and vec_ack=1 at T+1, exactly one write.
- clr_start with CLEAR_LEN=16, no other requests:
  - 16 consecutive writes of 0 to addresses 0..15.
  - clr_busy high 16 cycles, then clr_done pulse, then IDLE.
  - A second clr_start mid-clear is ignored.
- Clear running plus continuous vec_req: vector granted on the 9th waiting cycle (STARVE_MAX=8). Clear resumes at the held address, and the total clear writes still equal CLEAR_LEN.
- Continuous scan_req for 20 cycles with vec_req and clear active: 20 scan reads, zero vector/clear writes during that window, and both proceed afterward.
- Reset asserted at clear address 5: clr_busy=0 the cycle after reset, no clr_done, counter restarts at 0 on the next clr_start.
